// File: rtl/hdmi_log_reader_if.sv
// Bus bundle for the HDMI log reader: FIFO read side plus the byte stream
// toward the USB host path. The reader uses the master view; the FIFO and
// the downstream packetizer together form the slave view.
interface hdmi_log_reader_if;
  logic        log_empty;
  logic        log_read;
  logic [39:0] log_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    input  log_empty,
    input  log_data,
    input  out_ready,
    output log_read,
    output out_data,
    output out_valid,
    output out_last
  );

  modport slave (
    output log_empty,
    output log_data,
    output out_ready,
    input  log_read,
    input  out_data,
    input  out_valid,
    input  out_last
  );
endinterface

// File: rtl/hdmi_log_reader.sv
// HDMI log reader: pops 40-bit words (four packed 10-bit TMDS symbols) from
// the non-show-ahead log FIFO and emits each as five bytes, MSB first, on a
// valid/ready stream. out_last flags the final byte of every BURST_WORDS-word
// burst so the packetizer can close a USB packet. Single clock domain.
module hdmi_log_reader #(
  parameter int unsigned BURST_WORDS = 102
) (
  input  logic              log_clk,
  input  logic              reset_n,
  input  logic              enable,
  hdmi_log_reader_if.master log_bus,
  output logic [31:0]       words_read
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  // Burst counter value at which the closing byte carries out_last.
  localparam logic [15:0] BURST_LAST = 16'(BURST_WORDS - 32'd1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        log_read_r;
  logic        log_read_nxt_s;
  logic [7:0]  out_data_r;
  logic [7:0]  out_data_nxt_s;
  logic        out_valid_r;
  logic        out_valid_nxt_s;
  logic        out_last_r;
  logic        out_last_nxt_s;
  logic [31:0] words_read_r;
  logic [31:0] words_read_nxt_s;
  logic [2:0]  byte_idx_r;
  logic [2:0]  byte_idx_nxt_s;
  logic [15:0] burst_cnt_r;
  logic [15:0] burst_cnt_nxt_s;
  logic [39:0] shift_r;
  logic [39:0] shift_nxt_s;
  logic        accept_s;
  logic        pop_s;

  // A byte leaves only on a full handshake; a pop needs permission and data.
  assign accept_s = out_valid_r & log_bus.out_ready;
  assign pop_s    = enable & ~log_bus.log_empty;

  assign log_bus.log_read  = log_read_r;
  assign log_bus.out_data  = out_data_r;
  assign log_bus.out_valid = out_valid_r;
  assign log_bus.out_last  = out_last_r;
  assign words_read        = words_read_r;

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge log_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      log_read_r   <= 1'b0;
      out_data_r   <= 8'h00;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      words_read_r <= 32'd0;
      byte_idx_r   <= 3'd0;
      burst_cnt_r  <= 16'd0;
      shift_r      <= 40'd0;
    end else begin
      state_r      <= state_nxt_s;
      log_read_r   <= log_read_nxt_s;
      out_data_r   <= out_data_nxt_s;
      out_valid_r  <= out_valid_nxt_s;
      out_last_r   <= out_last_nxt_s;
      words_read_r <= words_read_nxt_s;
      byte_idx_r   <= byte_idx_nxt_s;
      burst_cnt_r  <= burst_cnt_nxt_s;
      shift_r      <= shift_nxt_s;
    end
  end

  // Next-state logic: enable and log_empty matter only in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: state_nxt_s = LOAD;
      LOAD: state_nxt_s = SEND;
      SEND: begin
        if (accept_s && (byte_idx_r == 3'd4)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the byte shifter.
  always_comb begin
    log_read_nxt_s   = log_read_r;
    out_data_nxt_s   = out_data_r;
    out_valid_nxt_s  = out_valid_r;
    out_last_nxt_s   = out_last_r;
    words_read_nxt_s = words_read_r;
    byte_idx_nxt_s   = byte_idx_r;
    burst_cnt_nxt_s  = burst_cnt_r;
    shift_nxt_s      = shift_r;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          log_read_nxt_s   = 1'b1;
          words_read_nxt_s = words_read_r + 32'd1;
        end else begin
          log_read_nxt_s   = 1'b0;
        end
      end
      READ: begin
        // FIFO data lands during LOAD, one cycle after the read strobe.
        log_read_nxt_s = 1'b0;
      end
      LOAD: begin
        shift_nxt_s     = log_bus.log_data;
        out_data_nxt_s  = log_bus.log_data[39:32];
        out_valid_nxt_s = 1'b1;
        out_last_nxt_s  = 1'b0;
        byte_idx_nxt_s  = 3'd0;
      end
      SEND: begin
        if (accept_s) begin
          if (byte_idx_r < 3'd4) begin
            shift_nxt_s    = {shift_r[31:0], 8'h00};
            out_data_nxt_s = shift_r[31:24];
            byte_idx_nxt_s = byte_idx_r + 3'd1;
            // Only the fifth byte of the burst-closing word is flagged.
            out_last_nxt_s = (byte_idx_r == 3'd3) && (burst_cnt_r == BURST_LAST);
          end else begin
            out_valid_nxt_s = 1'b0;
            out_last_nxt_s  = 1'b0;
            if (burst_cnt_r == BURST_LAST) begin
              burst_cnt_nxt_s = 16'd0;
            end else begin
              burst_cnt_nxt_s = burst_cnt_r + 16'd1;
            end
          end
        end else begin
          // Stall: everything presented downstream holds.
          out_valid_nxt_s = out_valid_r;
        end
      end
      default: begin
        log_read_nxt_s   = 1'b0;
        out_data_nxt_s   = 8'h00;
        out_valid_nxt_s  = 1'b0;
        out_last_nxt_s   = 1'b0;
        byte_idx_nxt_s   = 3'd0;
        shift_nxt_s      = 40'd0;
      end
    endcase
  end

endmodule

// File: doc/hdmi_log_reader.md
Name: hdmi_log_reader

Overview:
- Read-side drain for the HDMI channel tap's dual-clock log FIFO.
- Pops 40-bit log words, each holding four packed 10-bit TMDS symbols, and serializes each word into five bytes on a valid/ready byte stream for the USB host path.
- Marks burst boundaries so the downstream packetizer can close USB packets.
- Runs entirely in the log_clk domain.

Parameters:
- BURST_WORDS, 102, number of log words per burst; out_last marks the final byte of each burst (102 x 5 = 510 bytes, fits a 512-byte USB packet). Legal range 1..65535.

Ports:
- log_clk  in  1  log domain clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new FIFO pops; a word in progress always completes.
- log_empty  in  1  FIFO read-side empty flag.
- log_read  out  1  FIFO read request; single-cycle pulse per word.
- log_data  in  40  FIFO read data; valid the cycle after log_read is sampled high (non-show-ahead FIFO).
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts byte when out_valid && out_ready.
- out_last  out  1  final byte of a burst; qualified by out_valid.
- words_read  out  32  count of words popped; wraps at 2^32.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - log_read=0, out_valid=0, out_last=0, out_data=0, words_read=0.
  - State=IDLE, byte index=0, burst count=0, shift register=0.
- FSM states are IDLE, READ, LOAD, SEND. All outputs are registered.
- IDLE:
  - If enable=1 and log_empty=0: log_read<=1, words_read<=words_read+1, go to READ.
  - Otherwise stay in IDLE.
- READ: log_read<=0, go to LOAD. This is exactly one log_read cycle per word.
- LOAD: shift register<=log_data, out_data<=log_data[39:32], out_valid<=1, byte index<=0, go to SEND.
- Byte order is MSB first: bytes are [39:32], [31:24], [23:16], [15:8], [7:0]. This preserves symbol arrival order, because the oldest symbol sits in [39:30].
- SEND, on each out_valid && out_ready:
  - If byte index<4: shift left 8, present the next byte, increment the index.
  - If byte index==4: out_valid<=0 and go to IDLE.
  - Burst count increments on that final accept, and wraps to 0 after BURST_WORDS-1.
- Stall: while out_valid=1 and out_ready=0, out_data, out_valid and out_last hold stable. out_valid never drops without a handshake.
- out_last=1 only while presenting byte index 4 with burst count==BURST_WORDS-1. It is 0 otherwise.
- Latency:
  - log_empty deasserts while in IDLE (cycle k), so log_read is high in cycle k+1.
  - The first byte is valid in cycle k+3.
  - Minimum 8 cycles per word (5 SEND + IDLE + READ + LOAD) with out_ready held 1.
- enable deasserted mid-word: the current word finishes all 5 bytes, then the block stays in IDLE. enable is only sampled in IDLE.
- log_empty asserting while in READ/LOAD/SEND has no effect; it is only sampled in IDLE.
- log_read is never asserted while log_empty=1 (sampled the same cycle in IDLE). FIFO underflow is impossible.
- Burst count persists across idle gaps. A burst may span FIFO-empty periods; there is no timeout flush.
- Reset mid-word: the partial word is discarded, and the burst count and words_read clear.
- BURST_WORDS=1: out_last is set on byte 4 of every word.

Test Plan:
- Reset, FIFO model preloaded with 0x0123456789, enable=1, out_ready=1 -> log_read is a single pulse. Bytes 01,23,45,67,89 appear on consecutive cycles, first byte valid 3 cycles after IDLE sees log_empty=0. words_read=1.
- Two words back-to-back, out_ready toggling 1,0,0,1 -> no byte is duplicated or dropped. out_data stays stable during stalls. Exactly 2 log_read pulses.
- BURST_WORDS=3, 7 words streamed -> out_last high on the last byte of words 3 and 6 only. Word 7 ends with out_last=0.
- enable dropped on byte 2 of word 1 with FIFO non-empty -> word 1 completes all 5 bytes, then no further log_read while enable=0. Reasserting enable resumes with word 2.
- reset_n pulsed low asynchronously mid-SEND (between clock edges) -> outputs clear immediately. After release, the next word is read fresh, and words_read restarts at 1.
- FIFO empty with enable=1 for 100 cycles -> log_read and out_valid stay 0 throughout.
